// File: rtl/xoodyak_seq_pkg.sv
// Shared types and constants for the Xoodyak command sequencer.
// FSM states, op codes and the default output-op mask.
package xoodyak_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_EMIT
    } seq_state_e;

    localparam logic [2:0] OP_IDLE    = 3'd0;
    localparam logic [2:0] OP_INIT    = 3'd1;
    localparam logic [2:0] OP_NONCE   = 3'd2;
    localparam logic [2:0] OP_ASSOC   = 3'd3;
    localparam logic [2:0] OP_CRYPT   = 3'd4;
    localparam logic [2:0] OP_DECRYPT = 3'd5;
    localparam logic [2:0] OP_SQUEEZE = 3'd6;
    localparam logic [2:0] OP_RATCHET = 3'd7;

    localparam logic [7:0] OUT_MASK_DEFAULT = 8'b0111_0000;

    function automatic int cont_bit(input int opw);
        return opw - 1;
    endfunction

endpackage

// File: rtl/xoodyak_cmd_fifo.sv
// Synchronous command FIFO with occupancy count.
// Head entry is read combinationally and stays until popped.
module xoodyak_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [AW:0]      cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem_q[rd_q];
    assign count   = cnt_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= wdata;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/xoodyak_op_sequencer.sv
// Flow-controlled command sequencer in front of xoodyak_build.
// Issues queued ops with repeats, returns outputs, aborts hung ops.
module xoodyak_op_sequencer
    import xoodyak_seq_pkg::*;
#(
    parameter int         DEPTH    = 8,
    parameter int         OPW      = 6,
    parameter int         DW       = 192,
    parameter int         REPW     = 4,
    parameter logic [7:0] OUT_MASK = OUT_MASK_DEFAULT,
    parameter int         TIMEOUT  = 1024
) (
    input  logic                   eph1,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [OPW-1:0]         cmd_op,
    input  logic [REPW-1:0]        cmd_rep,
    input  logic [DW-1:0]          cmd_data,
    output logic                   core_start,
    output logic [OPW-1:0]         core_opmode,
    output logic [DW-1:0]          core_textin,
    input  logic                   core_finished,
    input  logic [DW-1:0]          core_textout,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [DW-1:0]          res_data,
    output logic [OPW-1:0]         res_op,
    output logic                   busy,
    output logic                   err_timeout,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int FW  = OPW + REPW + DW;
    localparam int WDW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    seq_state_e      state_q, state_d;
    logic [OPW-1:0]  op_q, op_d;
    logic [DW-1:0]   data_q, data_d;
    logic [REPW-1:0] rep_q, rep_d;
    logic [WDW-1:0]  wd_q, wd_d;
    logic [DW-1:0]   res_data_q, res_data_d;
    logic [OPW-1:0]  res_op_q, res_op_d;
    logic            err_q, err_d;

    logic            fifo_push, fifo_pop;
    logic            fifo_full, fifo_empty;
    logic [FW-1:0]   fifo_rdata;
    logic            step;

    assign cmd_ready = ~fifo_full;
    assign fifo_push = cmd_valid & ~fifo_full;

    xoodyak_cmd_fifo #(
        .WIDTH(FW),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (eph1),
        .rst  (reset),
        .push (fifo_push),
        .pop  (fifo_pop),
        .wdata({cmd_op, cmd_rep, cmd_data}),
        .rdata(fifo_rdata),
        .count(fifo_count),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        data_d     = data_q;
        rep_d      = rep_q;
        wd_d       = wd_q;
        res_data_d = res_data_q;
        res_op_d   = res_op_q;
        err_d      = err_q;
        fifo_pop   = 1'b0;
        step       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    op_d    = fifo_rdata[FW-1 -: OPW];
                    rep_d   = fifo_rdata[DW +: REPW];
                    data_d  = fifo_rdata[DW-1:0];
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wd_d    = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A finish in the same cycle as the timeout takes priority.
                if (core_finished) begin
                    if (OUT_MASK[op_q[2:0]]) begin
                        res_data_d = core_textout;
                        res_op_d   = op_q;
                        state_d    = ST_EMIT;
                    end else begin
                        step = 1'b1;
                    end
                end else if (TIMEOUT != 0 && wd_q == WD_LAST) begin
                    err_d    = 1'b1;
                    fifo_pop = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_EMIT: begin
                if (res_ready) step = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        if (step) begin
            if (rep_q != '0) begin
                rep_d   = rep_q - 1'b1;
                state_d = ST_ISSUE;
            end else begin
                fifo_pop = 1'b1;
                state_d  = ST_IDLE;
            end
        end
    end

    always_ff @(posedge eph1 or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            data_q     <= '0;
            rep_q      <= '0;
            wd_q       <= '0;
            res_data_q <= '0;
            res_op_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            data_q     <= data_d;
            rep_q      <= rep_d;
            wd_q       <= wd_d;
            res_data_q <= res_data_d;
            res_op_q   <= res_op_d;
            err_q      <= err_d;
        end
    end

    logic active;
    assign active      = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign core_start  = (state_q == ST_ISSUE);
    assign core_opmode = active ? op_q : '0;
    assign core_textin = active ? data_q : '0;
    assign res_valid   = (state_q == ST_EMIT);
    assign res_data    = res_data_q;
    assign res_op      = res_op_q;
    assign busy        = (state_q != ST_IDLE) || !fifo_empty;
    assign err_timeout = err_q;

endmodule

// File: doc/xoodyak_op_sequencer.md
# xoodyak_op_sequencer

Parametrised command sequencer between a host and `xoodyak_build`. Buffers opmode and data commands in a FIFO, each with a repeat count, and issues them one at a time to the core with a `start` pulse. It waits for `finished` and returns `textout` for output-producing ops through a valid/ready result port. A watchdog aborts a hung operation. It replaces hard-coded opmode tables and free-running opmode counters with a flow-controlled, reusable front end.

## Interface
Parameters:
- `DEPTH`, default 8: command FIFO entries (power of 2, ≥2).
- `OPW`, default 6: opmode width. Bit OPW-1 is the continue flag; bits 2:0 are the op code.
- `DW`, default 192: text/data width.
- `REPW`, default 4: repeat-count width.
- `OUT_MASK`, default 8'b0111_0000: bit k set means op code k returns `textout` (crypt, decrypt, squeeze).
- `TIMEOUT`, default 1024: maximum cycles waiting for `core_finished`; 0 disables the watchdog.

Ports:
- `eph1` in 1: clock. One clock domain.
- `reset` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: FIFO can accept a command.
- `cmd_op` in OPW: opmode.
- `cmd_rep` in REPW: extra repetitions. Total issues = `cmd_rep` + 1.
- `cmd_data` in DW: textin for the command.
- `core_start` out 1: one-cycle start pulse to the core.
- `core_opmode` out OPW: opmode to the core.
- `core_textin` out DW: textin to the core.
- `core_finished` in 1: core done, single-cycle pulse.
- `core_textout` in DW: core output, valid while `core_finished`.
- `res_valid` out 1: result available.
- `res_ready` in 1: result consumed.
- `res_data` out DW: captured textout.
- `res_op` out OPW: opmode that produced the result.
- `busy` out 1: FSM not in IDLE, or FIFO not empty.
- `err_timeout` out 1: sticky watchdog flag, cleared only by reset.
- `fifo_count` out $clog2(DEPTH)+1: occupied FIFO entries.

## Operation
- Push happens when `cmd_valid & cmd_ready`. `cmd_ready` = (`fifo_count` < DEPTH). It is registered-state based and does not depend on a same-cycle pop.
- FSM states:
  - IDLE: if the FIFO is not empty, load the head into working registers (op, data, rep_ctr=`cmd_rep`) and go to ISSUE.
  - ISSUE: `core_start`=1 for exactly this cycle; clear the watchdog; go to WAIT.
  - WAIT: on `core_finished`:
    - if OUT_MASK[op[2:0]] is set, capture `core_textout` into `res_data` and go to EMIT;
    - otherwise perform the repetition step.
    - If the watchdog reaches TIMEOUT, set `err_timeout`, pop the command, drop the remaining repetitions, and go to IDLE.
  - EMIT: hold `res_valid`=1 with stable `res_data`/`res_op` until `res_ready`, then perform the repetition step.
- Repetition step:
  - rep_ctr ≠ 0: decrement it and go to ISSUE with the same op and data.
  - rep_ctr = 0: pop the FIFO head and go to IDLE.
- `core_opmode`/`core_textin` hold the working registers from ISSUE through the end of WAIT. Both read 0 in IDLE.
- The continue bit is passed to the core unchanged on every repetition. Op code 0 (idle) is still issued and still waits for `core_finished`.
- `core_finished` outside WAIT is ignored.

## Timing
- Reset values: `cmd_ready`=1, `core_start`=0, `core_opmode`=0, `core_textin`=0, `res_valid`=0, `res_data`=0, `res_op`=0, `busy`=0, `err_timeout`=0, `fifo_count`=0. FSM=IDLE, FIFO empty.
- Command push at edge t, FIFO previously empty and FSM in IDLE: ISSUE during cycle t+1→t+2, so `core_start` is high in the cycle after the load.
- `core_finished` sampled at edge f:
  - output op: `res_valid` high from f, i.e. the next cycle.
  - non-output op with repetitions left: `core_start` for the next repetition follows in cycle f+1.
- Result handshake at edge r: `res_valid` low after r, and the next ISSUE or IDLE follows at r.
- Pop and push in the same cycle: `fifo_count` is unchanged. When full, the push is refused because `cmd_ready`=0 that cycle.
- A wrapping FIFO pointer never corrupts data; DEPTH consecutive pushes fill the FIFO exactly.
- The watchdog counts WAIT cycles from 1. The abort fires at the edge where the count equals TIMEOUT. If `core_finished` and the timeout occur in the same cycle, `core_finished` wins.
- An asynchronous reset mid-operation immediately returns every output to its reset value and empties the FIFO.

## Structure
- Package `xoodyak_seq_pkg` holds:
  - FSM state enum (IDLE, ISSUE, WAIT, EMIT);
  - op code constants (IDLE=0, INIT=1, NONCE=2, ASSOC=3, CRYPT=4, DECRYPT=5, SQUEEZE=6, RATCHET=7);
  - default OUT_MASK;
  - continue-bit index function.
- Sub-module `xoodyak_cmd_fifo`: parametrised synchronous FIFO (WIDTH = OPW+REPW+DW, DEPTH) with count, full and empty outputs and asynchronous reset. It is instantiated once.

## Test plan
- Reset released, then push op 6'h21 rep 0 with a stub core returning finished 5 cycles after start: exactly one `core_start`, no `res_valid`, `busy` ends 0, `fifo_count` 0.
- Push op 6'h24 (crypt), rep 2, data 192'h4d4e…4b4c, with the stub returning textout = textin ^ 1: three `core_start` pulses and three results, each `res_data` = data ^ 1, `res_op` = 6'h24.
- Hold `res_ready`=0 for 10 cycles during EMIT: `res_valid` and `res_data` stay stable, no new `core_start`, and the FIFO is not popped.
- Push 8 commands with DEPTH=8 while the core is stalled: `cmd_ready` drops after the 8th, the 9th is refused, and order is preserved on drain.
- TIMEOUT=16 with the core never finishing: `err_timeout`=1 at cycle 16 of WAIT, the command is dropped, and the next queued command issues.
- Assert `reset` while in WAIT with 3 commands queued: all outputs immediately return to reset values, and no start is issued afterwards until a new push.
